// File: rtl/fetch_ctrl_pkg.sv
// fetch_pkg: shared encodings, state enum and control bundle for the fetch sequencer.
package fetch_pkg;
  localparam int LONG_BIT = 31;
  typedef enum logic [3:0] {
    PLACE_SEQ, PLACE_V0, PLACE_V2, PLACE_V4, PLACE_V6,
    PLACE_IVT, PLACE_RET, PLACE_CALL, PLACE_RESET
  } place_e;
  typedef enum logic [1:0] {SEL_HOLD = 2'd0, SEL_P2 = 2'd1, SEL_P4 = 2'd2} sel_e;
  typedef enum logic [1:0] {S_RESET, S_RUN, S_DRAIN, S_VECTOR} state_e;
  typedef struct packed {
    sel_e   sel;
    place_e place;
    logic   en;
    logic   flush;
    logic   ack;
  } ctl_t;
  function automatic logic is_long(input logic [31:0] inst);
    return inst[LONG_BIT];
  endfunction
  // exception 1/2/3 map onto fixed vectors 2/4/6
  function automatic place_e exc_place(input logic [1:0] code);
    return place_e'(4'(code) + 4'd1);
  endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: request inputs and fetch-stage controls of the fetch sequencer.
interface fetch_ctrl_if #(parameter int IDX_W = 3);
  logic             stall;
  logic             inst_long;
  logic [1:0]       exc_code;
  logic             ret_req;
  logic             call_req;
  logic             int_req;
  logic [IDX_W-1:0] int_index_in;
  logic [1:0]       pc_select;
  logic [3:0]       pc_place;
  logic [IDX_W-1:0] index;
  logic             enableBuf;
  logic             flush;
  logic             int_ack;
  modport master (
    input  stall, inst_long, exc_code, ret_req, call_req, int_req, int_index_in,
    output pc_select, pc_place, index, enableBuf, flush, int_ack
  );
  modport slave (
    output stall, inst_long, exc_code, ret_req, call_req, int_req, int_index_in,
    input  pc_select, pc_place, index, enableBuf, flush, int_ack
  );
endinterface

// File: rtl/fetch_ctrl_int_pending_reg.sv
// int_pending_reg: pending-interrupt flag with its latched index; captures only when unmasked and idle.
module int_pending_reg #(parameter int IDX_W = 3) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             mask,
  input  logic             clr,
  input  logic [IDX_W-1:0] idx_in,
  output logic             pending,
  output logic [IDX_W-1:0] idx
);
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      idx     <= '0;
    end else if (clr) begin
      pending <= 1'b0;
    end else if (req && !mask && !pending) begin
      pending <= 1'b1;
      idx     <= idx_in;
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: registered sequencer arbitrating sequential fetch, stalls, redirects and drained interrupts.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int IDX_W        = 3
) (
  input logic        clk,
  input logic        reset,
  fetch_ctrl_if.master bus
);
  localparam int CW = DRAIN_CYCLES > 0 ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DRAIN_INIT = CW'(DRAIN_CYCLES > 0 ? DRAIN_CYCLES - 1 : 0);
  localparam ctl_t RESET_CTL = ctl_t'{SEL_HOLD, PLACE_RESET, 1'b0, 1'b1, 1'b0};
  localparam ctl_t BUBBLE    = ctl_t'{SEL_HOLD, PLACE_SEQ, 1'b0, 1'b0, 1'b0};
  localparam ctl_t VEC_CTL   = ctl_t'{SEL_HOLD, PLACE_IVT, 1'b1, 1'b1, 1'b1};
  state_e           st, nst;
  logic [CW-1:0]    cnt, cnt_n;
  ctl_t             o, o_n, run_ctl;
  logic [IDX_W-1:0] idx_q, idx_n, lat_idx;
  logic             pend, redirect;
  int_pending_reg #(.IDX_W(IDX_W)) u_pend (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.int_req),
    .mask    (st != S_RUN),
    .clr     (nst == S_VECTOR),
    .idx_in  (bus.int_index_in),
    .pending (pend),
    .idx     (lat_idx)
  );
  assign redirect = bus.exc_code != 2'd0 || bus.ret_req || bus.call_req;
  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= S_RESET;
      cnt   <= '0;
      o     <= RESET_CTL;
      idx_q <= '0;
    end else begin
      st    <= nst;
      cnt   <= cnt_n;
      o     <= o_n;
      idx_q <= idx_n;
    end
  end
  // in DRAIN only an exception may interrupt the countdown; the pending flag survives it
  always_comb begin
    nst   = S_RUN;
    cnt_n = cnt;
    if (st == S_DRAIN) begin
      if (bus.exc_code != 2'd0) nst = S_RUN;
      else if (cnt == '0) nst = S_VECTOR;
      else begin
        nst   = S_DRAIN;
        cnt_n = cnt - 1'b1;
      end
    end else if (!redirect && pend) begin
      nst   = DRAIN_CYCLES == 0 ? S_VECTOR : S_DRAIN;
      cnt_n = DRAIN_INIT;
    end
  end
  // registered outputs describe the state being entered
  always_comb begin
    run_ctl = bus.exc_code != 2'd0 ? ctl_t'{SEL_HOLD, exc_place(bus.exc_code), 1'b1, 1'b1, 1'b0} :
              bus.ret_req          ? ctl_t'{SEL_HOLD, PLACE_RET, 1'b1, 1'b1, 1'b0} :
              bus.call_req         ? ctl_t'{SEL_HOLD, PLACE_CALL, 1'b1, 1'b1, 1'b0} :
              bus.stall            ? BUBBLE :
              ctl_t'{bus.inst_long ? SEL_P4 : SEL_P2, PLACE_SEQ, 1'b1, 1'b0, 1'b0};
    o_n     = nst == S_VECTOR ? VEC_CTL : nst == S_DRAIN ? BUBBLE : run_ctl;
    idx_n   = nst == S_VECTOR ? lat_idx : '0;
  end
  assign bus.pc_select = o.sel;
  assign bus.pc_place  = o.place;
  assign bus.enableBuf = o.en;
  assign bus.flush     = o.flush;
  assign bus.int_ack   = o.ack;
  assign bus.index     = idx_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table for fetch_ctrl with DRAIN_CYCLES=3.
module tb_fetch_ctrl;
  typedef struct packed {
    logic       r, s, l;
    logic [1:0] e;
    logic       rt, cl, ir;
    logic [2:0] ii;
    logic [1:0] sel;
    logic [3:0] pl;
    logic       en, fl, ack;
    logic [2:0] ix;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t tv[$];
  always #5 clk = ~clk;
  fetch_ctrl_if #(.IDX_W(3)) bus ();
  fetch_ctrl #(.DRAIN_CYCLES(3), .IDX_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  function automatic vec_t mk(input int r, s, l, e, rt, cl, ir, ii, sel, pl, en, fl, ack, ix);
    vec_t v;
    v.r = r[0]; v.s = s[0]; v.l = l[0]; v.e = e[1:0];
    v.rt = rt[0]; v.cl = cl[0]; v.ir = ir[0]; v.ii = ii[2:0];
    v.sel = sel[1:0]; v.pl = pl[3:0]; v.en = en[0]; v.fl = fl[0]; v.ack = ack[0]; v.ix = ix[2:0];
    return v;
  endfunction
  task automatic apply(input vec_t v, input string name);
    logic [11:0] got, want;
    reset = v.r; bus.stall = v.s; bus.inst_long = v.l; bus.exc_code = v.e;
    bus.ret_req = v.rt; bus.call_req = v.cl; bus.int_req = v.ir; bus.int_index_in = v.ii;
    @(posedge clk);
    #1;
    got  = {bus.pc_select, bus.pc_place, bus.enableBuf, bus.flush, bus.int_ack, bus.index};
    want = {v.sel, v.pl, v.en, v.fl, v.ack, v.ix};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got sel=%0d place=%0d en=%0b flush=%0b ack=%0b idx=%0d, expected sel=%0d place=%0d en=%0b flush=%0b ack=%0b idx=%0d",
               name, bus.pc_select, bus.pc_place, bus.enableBuf, bus.flush, bus.int_ack, bus.index,
               v.sel, v.pl, v.en, v.fl, v.ack, v.ix);
    end
  endtask
  initial begin
    // reset held three cycles, outputs checked every cycle
    for (int i = 0; i < 3; i++) apply(mk(1,0,0,0,0,0,0,0, 0,8,0,1,0,0), $sformatf("reset_hold%0d", i));
    //            r s l e rt cl ir ii   sel pl en fl ack ix
    tv.push_back(mk(0,0,0,0,0,0,0,0,  1,0,1,0,0,0));
    tv.push_back(mk(0,0,1,0,0,0,0,0,  2,0,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,  1,0,1,0,0,0));
    tv.push_back(mk(0,1,0,0,0,0,0,0,  0,0,0,0,0,0));
    tv.push_back(mk(0,1,0,0,0,0,0,0,  0,0,0,0,0,0));
    tv.push_back(mk(0,0,1,0,0,0,0,0,  2,0,1,0,0,0));
    tv.push_back(mk(0,1,0,0,1,1,0,0,  0,6,1,1,0,0));
    tv.push_back(mk(0,1,0,0,0,0,0,0,  0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,1,0,0,  0,7,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,  1,0,1,0,0,0));
    // interrupt 5: three bubbles then the vector; extra requests meanwhile are dropped
    tv.push_back(mk(0,0,0,0,0,0,1,5,  1,0,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,1,3,  0,0,0,0,0,0));
    tv.push_back(mk(0,1,0,0,0,1,1,3,  0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,1,0,0,0,  0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,  0,5,1,1,1,5));
    tv.push_back(mk(0,0,1,0,0,0,0,0,  2,0,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,  1,0,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,  1,0,1,0,0,0));
    // exception in the second drain cycle restarts the drain
    tv.push_back(mk(0,0,0,0,0,0,1,5,  1,0,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,2,0,0,0,0,  0,3,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,  0,5,1,1,1,5));
    tv.push_back(mk(0,0,0,0,0,0,0,0,  1,0,1,0,0,0));
    // exception priority in RUN
    tv.push_back(mk(0,0,0,1,0,0,0,0,  0,2,1,1,0,0));
    tv.push_back(mk(0,0,0,3,1,0,0,0,  0,4,1,1,0,0));
    tv.push_back(mk(0,1,0,1,0,1,0,0,  0,2,1,1,0,0));
    // reset in mid-drain discards the pending interrupt
    tv.push_back(mk(0,0,0,0,0,0,1,6,  1,0,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,  0,8,0,1,0,0));
    for (int i = 0; i < 5; i++) tv.push_back(mk(0,0,0,0,0,0,0,0,  1,0,1,0,0,0));
    foreach (tv[i]) apply(tv[i], $sformatf("row%0d", i));
    // level int_req held across the vector: ignored while in VECTOR, recaptured once back in RUN
    apply(mk(0,0,0,0,0,0,1,4,  1,0,1,0,0,0), "held_capture");
    for (int i = 0; i < 3; i++) apply(mk(0,0,0,0,0,0,1,4,  0,0,0,0,0,0), $sformatf("held_drain%0d", i));
    apply(mk(0,0,0,0,0,0,1,4,  0,5,1,1,1,4), "held_vector");
    apply(mk(0,0,0,0,0,0,1,4,  1,0,1,0,0,0), "held_in_vector");
    apply(mk(0,0,0,0,0,0,1,4,  1,0,1,0,0,0), "held_recapture");
    apply(mk(0,0,0,0,0,0,0,0,  0,0,0,0,0,0), "held_redrain");
    apply(mk(1,0,0,0,0,0,0,0,  0,8,0,1,0,0), "final_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencer directly upstream of the fetch stage. Each cycle it drives the fetch stage's pc_select, pc_place, index and enableBuf controls. It arbitrates between sequential fetch, hazard stalls, call/return redirects, exceptions, and vectored interrupts (with pipeline drain). It also issues flush and interrupt-acknowledge to the rest of the core.

Parameters:
DRAIN_CYCLES, 3, bubble cycles inserted before an interrupt vector fetch (0 = vector immediately)
IDX_W, 3, width of interrupt index

Ports:
clk  in  1  core clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard stall request from decode
inst_long  in  1  fetched instruction is 32-bit (instruction bit LONG_BIT), else 16-bit
exc_code  in  2  00 none; 01/10/11 = exception 1/2/3
ret_req  in  1  return redirect (target already on fetch ret input)
call_req  in  1  call redirect (target already on fetch call input)
int_req  in  1  external interrupt request, level
int_index_in  in  IDX_W  interrupt number, sampled with int_req
pc_select  out  2  00 hold, 01 +2, 10 +4
pc_place  out  4  0 seq; 1..4 fixed vectors 0/2/4/6; 5 IVT+index; 6 ret; 7 call; 8 external reset value
index  out  IDX_W  interrupt index to fetch
enableBuf  out  1  fetch/decode buffer enable
flush  out  1  squash younger pipeline stages
int_ack  out  1  one-cycle interrupt acknowledge

Behaviour:
- All outputs registered; response appears the cycle after inputs are sampled (latency 1).
- reset=1 (any state, mid-drain included): state RESET; pc_place=8, pc_select=00, enableBuf=0, flush=1, int_ack=0, index=0; pending cleared, drain counter cleared. First edge with reset=0 goes to RUN.
- States: RESET, RUN, DRAIN, VECTOR.
- RUN priority, highest first (one action per cycle):
  1) exc_code!=0: pc_place=exc_code+1 (2..4), flush=1, enableBuf=1, select=00.
  2) ret_req: pc_place=6, flush=1, enableBuf=1. ret wins over a simultaneous call.
  3) call_req: pc_place=7, flush=1, enableBuf=1.
  4) Interrupt pending: go to DRAIN with counter=DRAIN_CYCLES-1, or to VECTOR directly if DRAIN_CYCLES=0.
  5) stall: pc_place=0, pc_select=00, enableBuf=0, flush=0.
  6) Otherwise: pc_place=0, pc_select=(inst_long ? 10 : 01), enableBuf=1, flush=0.
- Redirect outputs (pc_place!=0) last exactly one cycle, then revert to sequential/stall rules.
- Interrupt capture:
  - Pending sets when int_req=1, not already pending, and state is RUN; int_index_in is latched on that edge.
  - int_req while pending, DRAIN or VECTOR is ignored.
- DRAIN: pc_select=00, pc_place=0, enableBuf=0, flush=0; counter decrements each cycle.
  - Counter reaching 0 moves to VECTOR.
  - Exception during DRAIN: serviced as in RUN, drain aborted, pending retained, return to RUN (re-drain afterwards).
  - stall, call_req and ret_req are ignored in DRAIN.
- VECTOR (1 cycle): pc_place=5, index=latched index, flush=1, enableBuf=1, int_ack=1. Pending clears; next state RUN.
- Counter width is clog2(DRAIN_CYCLES+1); it never wraps (saturates at 0).

Decomposition:
- Package fetch_pkg holds:
  - pc_place encodings (PLACE_SEQ..PLACE_RESET)
  - pc_select encodings (SEL_HOLD, SEL_P2, SEL_P4)
  - state enum
  - LONG_BIT=31
- One sub-module: int_pending_reg (pending flag, latched index, set/clear/mask logic).

Test Plan:
- reset held 3 cycles, release, then inst_long=0,1,0 → outputs pc_place=8 during reset, then pc_select 01,10,01 with pc_place=0, enableBuf=1.
- stall=1 for 2 cycles in RUN → pc_select=00, enableBuf=0 for 2 cycles, then sequential resumes.
- call_req=1 and ret_req=1 together with stall=1 → one cycle pc_place=6, flush=1; the next cycle honours stall.
- int_req=1 with int_index_in=5, DRAIN_CYCLES=3 → 3 bubble cycles, then pc_place=5, index=5, int_ack=1 for one cycle, then RUN; a second int_req during drain is dropped.
- exc_code=10 in the 2nd drain cycle → pc_place=3, flush=1; drain restarts and the vector with index 5 is still delivered.
- reset asserted in mid-DRAIN → RESET outputs next cycle; after release there is no pending interrupt and no int_ack.
